// File: rtl/tdm_demultiplexer.sv
// Receive side of a 4-lane TDM link: collects one beat per slot and presents
// the lanes of each complete frame on registered outputs.
module tdm_demultiplexer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             frame_error,
  output logic             address0,
  output logic             address1
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] stage_q [3];
  logic [WIDTH-1:0] stage_d [3];
  logic [WIDTH-1:0] out_q   [4];
  logic [WIDTH-1:0] out_d   [4];
  logic             out_valid_q, out_valid_d;
  logic             frame_error_q, frame_error_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    stage_d       = stage_q;
    out_d         = out_q;
    out_valid_d   = 1'b0;
    frame_error_d = 1'b0;

    if (in_valid) begin
      if (frame_start) begin
        // A start beat always opens a new frame; inside an open frame it
        // aborts the partial one, which is simply overwritten later.
        frame_error_d = (state_q == COLLECT);
        stage_d[0]    = in_data;
        slot_d        = 2'd1;
        state_d       = COLLECT;
      end else if (state_q == COLLECT) begin
        case (slot_q)
          2'd1: begin
            stage_d[1] = in_data;
            slot_d     = 2'd2;
          end
          2'd2: begin
            stage_d[2] = in_data;
            slot_d     = 2'd3;
          end
          2'd3: begin
            // Lane 3 bypasses staging so the frame lands on this same edge.
            out_d[0]    = stage_q[0];
            out_d[1]    = stage_q[1];
            out_d[2]    = stage_q[2];
            out_d[3]    = in_data;
            out_valid_d = 1'b1;
            slot_d      = 2'd0;
            state_d     = HUNT;
          end
          default: begin
            slot_d = slot_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      stage_q       <= '{default: '0};
      out_q         <= '{default: '0};
      out_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      stage_q       <= stage_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign out_valid   = out_valid_q;
  assign frame_error = frame_error_q;
  assign address0    = slot_q[0];
  assign address1    = slot_q[1];

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer: tasks drive beats and push expected
// frames; a monitor pops and compares whenever out_valid is seen.
module tb_tdm_demultiplexer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         frame_start = 1'b0;
  logic [W-1:0] out0, out1, out2, out3;
  logic         out_valid, frame_error, address0, address1;

  int vectors = 0;
  int miscompares = 0;
  logic [4*W-1:0] exp_q [$];

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .frame_start(frame_start), .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .out_valid(out_valid), .frame_error(frame_error),
    .address0(address0), .address1(address1)
  );

  always #5 clk = ~clk;

  wire [4*W-1:0] outs = {out0, out1, out2, out3};
  wire [1:0]     addr = {address1, address0};

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_frame: got out_valid with outs=%h, no frame expected", outs);
      end else begin
        logic [4*W-1:0] e;
        e = exp_q.pop_front();
        if (outs !== e) begin
          miscompares++;
          $display("FAIL sb_frame: outs=%h expected %h", outs, e);
        end else
          $display("frame ok: outs=%h", outs);
      end
    end
    vectors++;
    if (out_valid === 1'b1 && frame_error === 1'b1) begin
      miscompares++;
      $display("FAIL pulse_overlap: out_valid=%b frame_error=%b expected not both 1", out_valid, frame_error);
    end
  end

  task automatic beat(input logic v, input logic fs, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    frame_start = fs;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
  endtask

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] req);
    // unused helper intentionally absent; inline checks used instead
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++;
    if ({outs, out_valid, frame_error, addr} !== {16'h0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state: outs=%h ov=%b fe=%b addr=%0d expected all 0", outs, out_valid, frame_error, addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    beat(1, 1, 4'h1);
    vectors++;
    if (addr !== 2'd1) begin miscompares++; $display("FAIL basic_addr1: addr=%0d expected 1", addr); end
    beat(1, 0, 4'h2);
    vectors++;
    if (addr !== 2'd2) begin miscompares++; $display("FAIL basic_addr2: addr=%0d expected 2", addr); end
    beat(1, 0, 4'h3);
    vectors++;
    if (addr !== 2'd3 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_addr3: addr=%0d ov=%b expected 3,0", addr, out_valid);
    end
    exp_q.push_back(16'h1234);
    beat(1, 0, 4'h4);
    vectors++;
    if (outs !== 16'h1234 || out_valid !== 1'b1 || addr !== 2'd0 || frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: outs=%h ov=%b addr=%0d fe=%b expected 1234,1,0,0", outs, out_valid, addr, frame_error);
    end
    idle();
    vectors++;
    if (out_valid !== 1'b0 || outs !== 16'h1234) begin
      miscompares++; $display("FAIL basic_pulse_len: ov=%b outs=%h expected 0,1234", out_valid, outs);
    end
    $display("basic frame applied");
  endtask

  task automatic test_premature();
    beat(1, 1, 4'h5);
    beat(1, 0, 4'h6);
    beat(1, 1, 4'h7);
    vectors++;
    if (frame_error !== 1'b1 || outs !== 16'h1234 || addr !== 2'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL premature_err: fe=%b outs=%h addr=%0d ov=%b expected 1,1234,1,0", frame_error, outs, addr, out_valid);
    end
    beat(1, 0, 4'h8);
    vectors++;
    if (frame_error !== 1'b0) begin miscompares++; $display("FAIL premature_err_len: fe=%b expected 0", frame_error); end
    beat(1, 0, 4'h9);
    vectors++;
    if (outs !== 16'h1234) begin miscompares++; $display("FAIL premature_hold: outs=%h expected 1234", outs); end
    exp_q.push_back(16'h789E);
    beat(1, 0, 4'hE);
    vectors++;
    if (outs !== 16'h789E || out_valid !== 1'b1 || frame_error !== 1'b0) begin
      miscompares++; $display("FAIL premature_new: outs=%h ov=%b fe=%b expected 789e,1,0", outs, out_valid, frame_error);
    end
    $display("premature-start frame applied");
  endtask

  task automatic test_hunt();
    beat(1, 0, 4'hF);
    beat(1, 0, 4'hF);
    beat(0, 1, 4'hC);
    vectors++;
    if (addr !== 2'd0 || out_valid !== 1'b0 || frame_error !== 1'b0 || outs !== 16'h789E) begin
      miscompares++;
      $display("FAIL hunt_ignore: addr=%0d ov=%b fe=%b outs=%h expected 0,0,0,789e", addr, out_valid, frame_error, outs);
    end
    // A frame_start now must open a clean frame, not an aborted one.
    beat(1, 1, 4'h3);
    vectors++;
    if (addr !== 2'd1 || frame_error !== 1'b0) begin
      miscompares++; $display("FAIL hunt_open: addr=%0d fe=%b expected 1,0", addr, frame_error);
    end
    beat(1, 0, 4'h2);
    beat(1, 0, 4'h1);
    exp_q.push_back(16'h3210);
    beat(1, 0, 4'h0);
    $display("hunt discard applied");
  endtask

  task automatic test_idle_gaps();
    beat(1, 1, 4'hA);
    repeat (3) begin
      idle();
      vectors++;
      if (addr !== 2'd1 || out_valid !== 1'b0) begin
        miscompares++; $display("FAIL gap_addr1: addr=%0d ov=%b expected 1,0", addr, out_valid);
      end
    end
    beat(1, 0, 4'hB);
    idle();
    vectors++;
    if (addr !== 2'd2) begin miscompares++; $display("FAIL gap_addr2: addr=%0d expected 2", addr); end
    beat(1, 0, 4'hC);
    exp_q.push_back(16'hABCD);
    beat(1, 0, 4'hD);
    vectors++;
    if (outs !== 16'hABCD || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL gap_done: outs=%h ov=%b expected abcd,1", outs, out_valid);
    end
    $display("idle-gap frame applied");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d [8];
    for (int i = 0; i < 8; i++) d[i] = W'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) begin
      if (i == 3) exp_q.push_back({d[0], d[1], d[2], d[3]});
      if (i == 7) exp_q.push_back({d[4], d[5], d[6], d[7]});
      beat(1, (i == 0 || i == 4), d[i]);
      vectors++;
      if (out_valid !== (i == 3 || i == 7) || frame_error !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: ov=%b fe=%b expected %b,0", i, out_valid, frame_error, (i == 3 || i == 7));
      end
    end
    vectors++;
    if (outs !== {d[4], d[5], d[6], d[7]}) begin
      miscompares++; $display("FAIL b2b_second: outs=%h expected %h", outs, {d[4], d[5], d[6], d[7]});
    end
    $display("back-to-back frames applied");
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d [4];
    beat(1, 1, 4'h6);
    beat(1, 0, 4'h7);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({outs, out_valid, frame_error, addr} !== {16'h0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL async_reset: outs=%h ov=%b fe=%b addr=%0d expected all 0", outs, out_valid, frame_error, addr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({d[0], d[1], d[2], d[3]});
      beat(1, (i == 0), d[i]);
      vectors++;
      if (frame_error !== 1'b0) begin
        miscompares++; $display("FAIL post_reset_err: fe=%b expected 0", frame_error);
      end
    end
    vectors++;
    if (outs !== {d[0], d[1], d[2], d[3]} || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_frame: outs=%h ov=%b expected %h,1", outs, out_valid, {d[0], d[1], d[2], d[3]});
    end
    $display("async reset mid-frame applied");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_premature();
    test_hunt();
    test_idle_gaps();
    test_back_to_back();
    test_async_reset();
    idle();
    idle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d frames pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
